// File: rtl/fc_seq_ctrl.sv
// Time-multiplexed fully connected layer sequencer: one signed MAC streams IN
// activation/weight pairs per neuron, applies ReLU and emits results on a valid/ready stream.
module fc_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int IN      = 128,
    parameter int NEURONS = 10,
    localparam int ACC_W  = 2*WIDTH + $clog2(IN),
    localparam int XW     = $clog2(IN),
    localparam int WW     = $clog2(IN*NEURONS),
    localparam int NW     = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [XW-1:0]    x_addr,
    input  logic [WIDTH-1:0] x_data,
    output logic [WW-1:0]    w_addr,
    input  logic [WIDTH-1:0] w_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [NW-1:0]    out_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t state_r, state_s;

    logic [XW-1:0]          i_r, i_s;
    logic [NW-1:0]          n_r, n_s;
    logic [WW-1:0]          w_addr_r, w_addr_s;
    logic [ACC_W-1:0]       acc_r, acc_s;
    logic                   rd_vld_r, rd_vld_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   out_valid_r, out_valid_s;
    logic [ACC_W-1:0]       out_data_r, out_data_s;
    logic [NW-1:0]          out_idx_r, out_idx_s;

    logic                   handshake_s;
    logic                   last_i_s;
    logic                   last_n_s;
    logic                   start_ok_s;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [ACC_W-1:0]       prod_ext_s;
    logic [ACC_W-1:0]       acc_next_s;

    assign handshake_s = out_valid_r && out_ready;
    assign last_i_s    = (i_r == XW'(IN-1));
    assign last_n_s    = (n_r == NW'(NEURONS-1));
    // a start arriving in the done cycle belongs to the finished layer and is dropped
    assign start_ok_s  = start && !done_r;
    assign prod_s      = $signed(x_data) * $signed(w_data);
    assign prod_ext_s  = {{(ACC_W-2*WIDTH){prod_s[2*WIDTH-1]}}, prod_s};
    assign acc_next_s  = rd_vld_r ? (acc_r + prod_ext_s) : acc_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  state_s = start_ok_s ? S_ISSUE : S_IDLE;
            S_ISSUE: state_s = last_i_s ? S_DRAIN : S_ISSUE;
            S_DRAIN: state_s = S_OUT;
            S_OUT: begin
                if (handshake_s) begin
                    state_s = last_n_s ? S_IDLE : S_ISSUE;
                end else begin
                    state_s = S_OUT;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Next values of counters, accumulator and registered outputs
    always_comb begin
        i_s         = i_r;
        n_s         = n_r;
        w_addr_s    = w_addr_r;
        acc_s       = acc_next_s;
        rd_vld_s    = (state_r == S_ISSUE);
        busy_s      = busy_r;
        done_s      = 1'b0;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_idx_s   = out_idx_r;
        case (state_r)
            S_IDLE: begin
                if (start_ok_s) begin
                    i_s      = {XW{1'b0}};
                    n_s      = {NW{1'b0}};
                    w_addr_s = {WW{1'b0}};
                    acc_s    = {ACC_W{1'b0}};
                    busy_s   = 1'b1;
                end else begin
                    busy_s   = busy_r;
                end
            end
            S_ISSUE: begin
                if (!last_i_s) begin
                    i_s      = i_r + 1'b1;
                    w_addr_s = w_addr_r + 1'b1;
                end else begin
                    i_s      = i_r;
                    w_addr_s = w_addr_r;
                end
            end
            S_DRAIN: begin
                // the final product lands this cycle, so the result is taken from acc_next_s
                out_valid_s = 1'b1;
                out_idx_s   = n_r;
                out_data_s  = acc_next_s[ACC_W-1] ? {ACC_W{1'b0}} : acc_next_s;
            end
            S_OUT: begin
                if (handshake_s) begin
                    out_valid_s = 1'b0;
                    if (last_n_s) begin
                        busy_s = 1'b0;
                        done_s = 1'b1;
                    end else begin
                        n_s      = n_r + 1'b1;
                        i_s      = {XW{1'b0}};
                        acc_s    = {ACC_W{1'b0}};
                        // w_addr still holds n*IN+IN-1, so +1 is the next neuron's base
                        w_addr_s = w_addr_r + 1'b1;
                    end
                end else begin
                    out_valid_s = out_valid_r;
                end
            end
            default: begin
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            i_r         <= {XW{1'b0}};
            n_r         <= {NW{1'b0}};
            w_addr_r    <= {WW{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            rd_vld_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {ACC_W{1'b0}};
            out_idx_r   <= {NW{1'b0}};
        end else begin
            i_r         <= i_s;
            n_r         <= n_s;
            w_addr_r    <= w_addr_s;
            acc_r       <= acc_s;
            rd_vld_r    <= rd_vld_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_idx_r   <= out_idx_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign x_addr    = i_r;
    assign w_addr    = w_addr_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Bench for fc_seq_ctrl (WIDTH=8, IN=4, NEURONS=2): directed layers plus randomized
// data and ready, checked against a dot-product/ReLU reference model.
module tb_fc_seq_ctrl;

    localparam int WIDTH   = 8;
    localparam int IN      = 4;
    localparam int NEURONS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  x_addr;
    logic [7:0]  x_data;
    logic [2:0]  w_addr;
    logic [7:0]  w_data;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    logic [0:0]  out_idx;

    logic signed [7:0] xm [IN];
    logic signed [7:0] wm [IN*NEURONS];

    int n_tests = 0;
    int n_fail  = 0;

    fc_seq_ctrl #(.WIDTH(WIDTH), .IN(IN), .NEURONS(NEURONS)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .x_addr(x_addr), .x_data(x_data), .w_addr(w_addr), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    // 1-cycle-latency memory models
    always @(posedge clk) begin
        x_data <= xm[x_addr];
        w_data <= wm[w_addr];
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input int n);
        int s;
        s = 0;
        for (int i = 0; i < IN; i++) s += int'(xm[i]) * int'(wm[n*IN+i]);
        return (s < 0) ? 0 : s;
    endfunction

    task automatic load(input int x0, input int x1, input int x2, input int x3,
                        input int w00, input int w01, input int w02, input int w03,
                        input int w10, input int w11, input int w12, input int w13);
        xm[0] = 8'(x0);  xm[1] = 8'(x1);  xm[2] = 8'(x2);  xm[3] = 8'(x3);
        wm[0] = 8'(w00); wm[1] = 8'(w01); wm[2] = 8'(w02); wm[3] = 8'(w03);
        wm[4] = 8'(w10); wm[5] = 8'(w11); wm[6] = 8'(w12); wm[7] = 8'(w13);
    endtask

    task automatic load_random();
        for (int i = 0; i < IN; i++) xm[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < IN*NEURONS; i++) wm[i] = 8'($urandom_range(0, 255));
    endtask

    // Runs one layer; k counts cycles after the start cycle T
    task automatic run_layer(input int bp, input bit rnd_ready, input bit timing, input bit poke);
        int exp_q[$];
        int k, hs, stall;
        bit done_seen, pend;
        logic [17:0] pd;
        logic [0:0]  pi;
        for (int n = 0; n < NEURONS; n++) exp_q.push_back(model(n));
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        k = 0; hs = 0; stall = 0; done_seen = 1'b0; pend = 1'b0;
        while (!done_seen && k < 300) begin
            @(negedge clk);
            if (timing && k >= 1 && k <= 4) begin
                check_val("x_addr_n0", x_addr, k-1);
                check_val("w_addr_n0", w_addr, k-1);
            end
            if (timing && k >= 7 && k <= 10) begin
                check_val("x_addr_n1", x_addr, k-7);
                check_val("w_addr_n1", w_addr, k-3);
            end
            if (pend) begin
                check_val("stall_data", out_data, pd);
                check_val("stall_idx", out_idx, pi);
            end
            if (out_valid && out_ready) begin
                if (hs < NEURONS) begin
                    check_val("out_data", out_data, exp_q[hs]);
                    check_val("out_idx", out_idx, hs);
                end else begin
                    check_val("extra_output", hs, NEURONS-1);
                end
                hs++;
                stall = 0;
                if (timing) check_val("out_time", k, 6*hs);
            end
            pend = out_valid && !out_ready;
            pd = out_data;
            pi = out_idx;
            if (k >= 1) check_val("busy", busy, !done);
            if (done) begin
                check_val("done_after_last", hs, NEURONS);
                if (timing) check_val("done_time", k, 13);
                done_seen = 1'b1;
            end
            @(posedge clk); #1;
            k++;
            start = poke ? (k == 3 || done) : 1'b0;
            if (out_valid && stall < bp) begin
                out_ready = 1'b0;
                stall++;
            end else if (rnd_ready) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
        end
        if (!done_seen) check_val("done_timeout", 0, 1);
        start = 1'b0;
        @(negedge clk);
        check_val("idle_busy", busy, 0);
        check_val("idle_done", done, 0);
        check_val("idle_valid", out_valid, 0);
    endtask

    initial begin
        int dcount;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        load(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_data", out_data, 0);
        check_val("rst_idx", out_idx, 0);
        check_val("rst_xaddr", x_addr, 0);
        check_val("rst_waddr", w_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // basic with exact timing and address trace
        load(1, 2, 3, 4, 1, 1, 1, 1, 2, 0, 0, 1);
        run_layer(0, 1'b0, 1'b1, 1'b0);

        // ReLU: -10 -> 0, +1 -> 1; then exactly zero
        load(1, 2, 3, 4, -1, -1, -1, -1, 1, 0, 0, 0);
        run_layer(0, 1'b0, 1'b0, 1'b0);
        load(1, 2, 3, 4, 1, 1, -1, 0, 0, 0, 0, 1);
        run_layer(0, 1'b0, 1'b0, 1'b0);

        // extremes: 65536 and a negative sum clamped to 0
        load(-128, -128, -128, -128, -128, -128, -128, -128, 127, 127, 127, 127);
        run_layer(0, 1'b0, 1'b0, 1'b0);
        check_val("model_max", model(0), 65536);

        // backpressure: five stall cycles at each OUT
        load(1, 2, 3, 4, 1, 1, 1, 1, 2, 0, 0, 1);
        run_layer(5, 1'b0, 1'b0, 1'b0);

        // start while busy and in the done cycle
        load(5, -3, 7, 1, 2, 2, -1, 4, -6, 1, 3, 0);
        run_layer(0, 1'b0, 1'b0, 1'b1);

        // reset during ISSUE of neuron 1
        load(1, 2, 3, 4, 1, 1, 1, 1, 2, 0, 0, 1);
        @(posedge clk); #1;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_data", out_data, 0);
        check_val("mid_rst_idx", out_idx, 0);
        check_val("mid_rst_xaddr", x_addr, 0);
        check_val("mid_rst_waddr", w_addr, 0);
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || out_valid || busy) dcount++;
        end
        check_val("mid_rst_quiet", dcount, 0);
        run_layer(0, 1'b0, 1'b1, 1'b0);

        // randomized data and ready
        for (int r = 0; r < 8; r++) begin
            load_random();
            run_layer((r == 7) ? 5 : 0, 1'b1, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
